hit_judge: RTL and testbench

//  Multi-lane, graded successor to the single-bongo hit detector; one instance serves all drums.
//  - Per lane: detects a new press on go[i] and grades it against the target distance stream.
//  - Grades: PERFECT / GOOD / MISS.
//  - Keeps a shared combo counter and a saturating score for the HUD and animation modules.

---
 rtl/hit_judge.sv | 99 +++++++++
 tb/tb_hit_judge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// hit_judge: multi-lane press grader (PERFECT/GOOD/MISS) with shared combo and saturating score.
// Optional go debounce filter is enabled by defining HIT_DEBOUNCE_EN.
module hit_judge #(
    parameter int LANES        = 2,
    parameter int XW           = 9,
    parameter int PERFECT_EPS  = 4,
    parameter int GOOD_EPS     = 10,
    parameter int PERFECT_PTS  = 3,
    parameter int GOOD_PTS     = 1,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic [LANES-1:0]   go,
    input  logic [LANES*XW-1:0] stream,
    input  logic [LANES-1:0]   target_valid,
    output logic [LANES-1:0]   hit,
    output logic [LANES-1:0]   perfect,
    output logic [LANES-1:0]   miss,
    output logic [7:0]         combo,
    output logic [15:0]        score
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRESS = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;
    if (LANES < 1 || LANES > 8 || GOOD_EPS <= PERFECT_EPS || DEBOUNCE_CYC < 1) begin : g_bad_params
        $error("hit_judge: illegal parameter combination");
    end
    logic [LANES-1:0] gf;
    logic [1:0]       st [LANES];
    logic [LANES-1:0] hit_n, perfect_n, miss_n;
    logic [16:0]      pts, score_sum;
    logic [8:0]       nh, combo_sum;
    logic [15:0]      score_n;
    logic [7:0]       combo_n;
`ifdef HIT_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
    logic [LANES-1:0] filt;
    logic [DBW-1:0]   cnt [LANES];
    // Filtered go follows raw go only after DEBOUNCE_CYC consecutive samples of a new level
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!reset_b) begin
                filt[i] <= 1'b0;
                cnt[i]  <= '0;
            end else if (go[i] == filt[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == DBW'(DEBOUNCE_CYC - 1)) begin
                filt[i] <= go[i];
                cnt[i]  <= '0;
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    assign gf = filt;
`else
    assign gf = go;
`endif
    // Grade presses accepted this edge and total their points and hits
    always_comb begin
        hit_n     = '0;
        perfect_n = '0;
        miss_n    = '0;
        pts       = '0;
        nh        = '0;
        for (int i = 0; i < LANES; i++) begin
            if (st[i] == IDLE && gf[i]) begin
                perfect_n[i] = target_valid[i] && stream[i*XW +: XW] < XW'(PERFECT_EPS);
                hit_n[i]     = target_valid[i] && stream[i*XW +: XW] < XW'(GOOD_EPS);
                miss_n[i]    = !hit_n[i];
            end
            pts = pts + (hit_n[i] ? (perfect_n[i] ? 17'(PERFECT_PTS) : 17'(GOOD_PTS)) : 17'd0);
            nh  = nh + 9'(hit_n[i]);
        end
        score_sum = {1'b0, score} + pts;
        score_n   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        combo_sum = {1'b0, combo} + nh;
        combo_n   = |miss_n ? 8'd0 : combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end
    // Lane FSMs, result pulses and shared counters; reset parks lanes in HELD
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            hit     <= '0;
            perfect <= '0;
            miss    <= '0;
            combo   <= '0;
            score   <= '0;
            for (int i = 0; i < LANES; i++) st[i] <= HELD;
        end else begin
            hit     <= hit_n;
            perfect <= perfect_n;
            miss    <= miss_n;
            combo   <= combo_n;
            score   <= score_n;
            for (int i = 0; i < LANES; i++) st[i] <= gf[i] ? (st[i] == IDLE ? PRESS : HELD) : IDLE;
        end
    end
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed self-checking bench for hit_judge (LANES=2, XW=9).
module tb_hit_judge;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [1:0]  go = 2'b00;
    logic [17:0] stream = '0;
    logic [1:0]  target_valid = 2'b00;
    logic [1:0]  hit, perfect, miss;
    logic [7:0]  combo;
    logic [15:0] score;
    int checks = 0;
    int errors = 0;

    hit_judge dut (
        .clk(clk), .reset_b(reset_b), .go(go), .stream(stream), .target_valid(target_valid),
        .hit(hit), .perfect(perfect), .miss(miss), .combo(combo), .score(score)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] g, input logic [8:0] d0, input logic [8:0] d1, input logic [1:0] v);
        @(negedge clk);
        go = g;
        stream = {d1, d0};
        target_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        go = 2'b00;
        tick();
        tick();
        @(negedge clk);
        reset_b = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (hit !== 2'b00) begin errors++; $display("FAIL reset_hit got %b want 00", hit); end
        checks++; if (perfect !== 2'b00) begin errors++; $display("FAIL reset_perfect got %b want 00", perfect); end
        checks++; if (miss !== 2'b00) begin errors++; $display("FAIL reset_miss got %b want 00", miss); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL reset_combo got %0d want 0", combo); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    endtask

`ifndef HIT_DEBOUNCE_EN
    task automatic test_perfect();
        drive(2'b01, 9'd2, 9'd0, 2'b11);
        tick();
        checks++; if (perfect !== 2'b01) begin errors++; $display("FAIL perf_perfect got %b want 01", perfect); end
        checks++; if (hit !== 2'b01) begin errors++; $display("FAIL perf_hit got %b want 01", hit); end
        checks++; if (miss !== 2'b00) begin errors++; $display("FAIL perf_miss got %b want 00", miss); end
        checks++; if (score !== 16'd3) begin errors++; $display("FAIL perf_score got %0d want 3", score); end
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL perf_combo got %0d want 1", combo); end
        tick();
        checks++; if (hit !== 2'b00) begin errors++; $display("FAIL perf_pulse_width got %b want 00", hit); end
        drive(2'b00, 9'd2, 9'd0, 2'b11);
        tick();
    endtask

    task automatic test_hold();
        int n = 0;
        drive(2'b01, 9'd2, 9'd0, 2'b11);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hit[0]) n++;
        end
        checks++; if (n != 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", n); end
        checks++; if (score !== 16'd6) begin errors++; $display("FAIL hold_score got %0d want 6", score); end
        drive(2'b00, 9'd2, 9'd0, 2'b11);
        tick();
    endtask

    task automatic test_boundary();
        drive(2'b01, 9'd4, 9'd0, 2'b01);
        tick();
        checks++; if (hit !== 2'b01 || perfect !== 2'b00) begin errors++; $display("FAIL bnd4_grade got hit=%b perfect=%b want hit=01 perfect=00", hit, perfect); end
        checks++; if (score !== 16'd7 || combo !== 8'd3) begin errors++; $display("FAIL bnd4_counts got score=%0d combo=%0d want 7 3", score, combo); end
        drive(2'b00, 9'd4, 9'd0, 2'b01);
        tick();
        drive(2'b01, 9'd10, 9'd0, 2'b01);
        tick();
        checks++; if (miss !== 2'b01 || hit !== 2'b00) begin errors++; $display("FAIL bnd10_grade got miss=%b hit=%b want miss=01 hit=00", miss, hit); end
        checks++; if (combo !== 8'd0 || score !== 16'd7) begin errors++; $display("FAIL bnd10_counts got combo=%0d score=%0d want 0 7", combo, score); end
        drive(2'b00, 9'd0, 9'd0, 2'b00);
        tick();
        drive(2'b10, 9'd0, 9'd0, 2'b01);
        tick();
        checks++; if (miss !== 2'b10 || hit !== 2'b00) begin errors++; $display("FAIL novalid got miss=%b hit=%b want miss=10 hit=00", miss, hit); end
        drive(2'b00, 9'd0, 9'd0, 2'b00);
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(2'b01, 9'd0, 9'd0, 2'b11);
            tick();
            drive(2'b00, 9'd0, 9'd0, 2'b11);
            tick();
        end
        checks++; if (combo !== 8'd7 || score !== 16'd21) begin errors++; $display("FAIL sim_pre got combo=%0d score=%0d want 7 21", combo, score); end
        drive(2'b11, 9'd0, 9'd5, 2'b11);
        tick();
        checks++; if (hit !== 2'b11 || perfect !== 2'b01) begin errors++; $display("FAIL sim_grade got hit=%b perfect=%b want 11 01", hit, perfect); end
        checks++; if (score !== 16'd25 || combo !== 8'd9) begin errors++; $display("FAIL sim_counts got score=%0d combo=%0d want 25 9", score, combo); end
        drive(2'b00, 9'd0, 9'd5, 2'b11);
        tick();
        drive(2'b11, 9'd0, 9'd50, 2'b11);
        tick();
        checks++; if (miss !== 2'b10 || hit !== 2'b01) begin errors++; $display("FAIL sim_miss got miss=%b hit=%b want 10 01", miss, hit); end
        checks++; if (score !== 16'd28 || combo !== 8'd0) begin errors++; $display("FAIL sim_miss_counts got score=%0d combo=%0d want 28 0", score, combo); end
        drive(2'b00, 9'd0, 9'd0, 2'b11);
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 10922; i++) begin
            drive(2'b11, 9'd0, 9'd0, 2'b11);
            tick();
            drive(2'b00, 9'd0, 9'd0, 2'b11);
            tick();
        end
        checks++; if (score !== 16'd65532 || combo !== 8'd255) begin errors++; $display("FAIL sat_pre got score=%0d combo=%0d want 65532 255", score, combo); end
        drive(2'b11, 9'd1, 9'd1, 2'b11);
        tick();
        checks++; if (score !== 16'hFFFF || combo !== 8'd255) begin errors++; $display("FAIL sat_clamp got score=%h combo=%0d want ffff 255", score, combo); end
        drive(2'b00, 9'd0, 9'd0, 2'b11);
        tick();
        drive(2'b01, 9'd3, 9'd0, 2'b11);
        tick();
        checks++; if (score !== 16'hFFFF || combo !== 8'd255 || perfect !== 2'b01) begin errors++; $display("FAIL sat_hold got score=%h combo=%0d perfect=%b want ffff 255 01", score, combo, perfect); end
        drive(2'b00, 9'd0, 9'd0, 2'b11);
        tick();
    endtask

    task automatic test_reset_mid_press();
        int n = 0;
        do_reset();
        drive(2'b01, 9'd2, 9'd0, 2'b11);
        tick();
        @(negedge clk);
        reset_b = 1'b0;
        tick();
        tick();
        checks++; if (score !== 16'd0 || combo !== 8'd0 || hit !== 2'b00) begin errors++; $display("FAIL midrst_clear got score=%0d combo=%0d hit=%b want 0 0 00", score, combo, hit); end
        @(negedge clk);
        reset_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ((hit | miss) != 2'b00) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL midrst_held got %0d pulse cycles want 0", n); end
        drive(2'b00, 9'd7, 9'd0, 2'b11);
        tick();
        drive(2'b01, 9'd7, 9'd0, 2'b11);
        tick();
        checks++; if (hit !== 2'b01 || perfect !== 2'b00 || score !== 16'd1) begin errors++; $display("FAIL midrst_regrade got hit=%b perfect=%b score=%0d want 01 00 1", hit, perfect, score); end
        drive(2'b00, 9'd0, 9'd0, 2'b11);
        tick();
    endtask
`else
    task automatic test_debounce();
        int n = 0;
        int at = 0;
        do_reset();
        drive(2'b01, 9'd2, 9'd0, 2'b11);
        for (int i = 0; i < 3; i++) tick();
        drive(2'b00, 9'd2, 9'd0, 2'b11);
        for (int i = 0; i < 10; i++) begin
            tick();
            if ((hit | miss) != 2'b00) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL db_glitch got %0d pulse cycles want 0", n); end
        drive(2'b01, 9'd2, 9'd0, 2'b11);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (hit[0]) begin n++; at = i; end
        end
        checks++; if (n != 1 || at != 5) begin errors++; $display("FAIL db_press got %0d pulses at cycle %0d want 1 at 5", n, at); end
        checks++; if (score !== 16'd3) begin errors++; $display("FAIL db_score got %0d want 3", score); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef HIT_DEBOUNCE_EN
        test_perfect();
        test_hold();
        test_boundary();
        test_simultaneous();
        test_reset_mid_press();
        test_saturation();
`else
        test_debounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
